// File: rtl/el2_pkg.sv
// Shared types and constants for the LSU data-access MPU checker.
package el2_pkg;

  // One run-time programmable access region
  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;   // 1 = don't-care address bit
    logic        ena;
    logic        wperm;
    logic        lock;   // sticky until reset
  } el2_mpu_region_t;

  // Verdict carried from d into m (address kept for fault capture)
  typedef struct packed {
    logic        valid;
    logic        access_fault;
    logic        misaligned_fault;
    logic [3:0]  mscause;
    logic [31:0] addr;
  } el2_mpu_verdict_t;

  localparam logic [3:0] MSC_NONE        = 4'd0;
  localparam logic [3:0] MSC_MISALIGN_SE = 4'd1;
  localparam logic [3:0] MSC_REGCROSS    = 4'd2;
  localparam logic [3:0] MSC_MPU         = 4'd3;
  localparam logic [3:0] MSC_WPERM       = 4'd7;

  // Half needs addr[0] clear, word needs addr[1:0] clear
  function automatic logic is_unaligned(input logic [1:0] size, input logic [1:0] lsb);
    is_unaligned = (size == 2'd1) ? lsb[0] :
                   (size == 2'd2) ? (lsb != 2'b00) : 1'b0;
  endfunction

endpackage

// File: rtl/el2_mpu_region_match.sv
// One address against the whole region table: any-hit plus the write
// permission of the lowest-numbered matching region.
module el2_mpu_region_match
  import el2_pkg::*;
#(
  parameter int NUM_REGIONS = 8
) (
  input  el2_mpu_region_t [NUM_REGIONS-1:0] regions,
  input  logic [31:0]                       addr,
  output logic                              hit,
  output logic                              wperm
);

  logic [NUM_REGIONS-1:0] match;

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_match
    assign match[i] = regions[i].ena &
                      ((addr | regions[i].mask) == (regions[i].base | regions[i].mask));
  end

  // Walk high to low so the lowest matching index has the last word on wperm
  always_comb begin
    hit   = |match;
    wperm = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) wperm = regions[i].wperm;
    end
  end

endmodule

// File: rtl/el2_lsu_mpu_check.sv
// LSU data-access checker: programmable region table, d-stage verdict
// registered into m, first-fault capture and optional saturating fault
// counter (enabled by RV_MPU_FAULT_CNT_EN; otherwise fault_cnt reads 0).
module el2_lsu_mpu_check
  import el2_pkg::*;
#(
  parameter int NUM_REGIONS = 8,
  parameter int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              csr_wr_en,
  input  logic [IDX_W-1:0]  csr_wr_idx,
  input  logic [31:0]       csr_wr_base,
  input  logic [31:0]       csr_wr_mask,
  input  logic              csr_wr_ena,
  input  logic              csr_wr_wperm,
  input  logic              csr_wr_lock,
  input  logic              req_valid_d,
  input  logic [31:0]       req_start_addr_d,
  input  logic [31:0]       req_end_addr_d,
  input  logic [1:0]        req_size_d,
  input  logic              req_store_d,
  input  logic              req_dma_d,
  input  logic              req_internal_d,
  input  logic              req_sideeffect_d,
  input  logic              stall_m,
  output logic              chk_valid_m,
  output logic              access_fault_m,
  output logic              misaligned_fault_m,
  output logic [3:0]        exc_mscause_m,
  input  logic              fault_cap_clr,
  output logic              fault_cap_valid,
  output logic [31:0]       fault_cap_addr,
  output logic [3:0]        fault_cap_cause,
  output logic [CNT_W-1:0]  fault_cnt
);

  el2_mpu_region_t [NUM_REGIONS-1:0] regions;
  el2_mpu_verdict_t                  vd, vm;

  // ---------------- region table ----------------
  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
    logic wr_hit;
    assign wr_hit = csr_wr_en & (32'(csr_wr_idx) == i) & ~regions[i].lock;

    // Entry updates unless locked; out-of-range indices never match any i
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        regions[i] <= '0;
      end else if (wr_hit) begin
        regions[i].base  <= csr_wr_base;
        regions[i].mask  <= csr_wr_mask;
        regions[i].ena   <= csr_wr_ena;
        regions[i].wperm <= csr_wr_wperm;
        regions[i].lock  <= csr_wr_lock;
      end
    end
  end

  // ---------------- d-stage check ----------------
  logic start_hit, start_wperm, end_hit, end_wperm;

  el2_mpu_region_match #(.NUM_REGIONS(NUM_REGIONS)) u_match_start (
    .regions (regions),
    .addr    (req_start_addr_d),
    .hit     (start_hit),
    .wperm   (start_wperm)
  );

  el2_mpu_region_match #(.NUM_REGIONS(NUM_REGIONS)) u_match_end (
    .regions (regions),
    .addr    (req_end_addr_d),
    .hit     (end_hit),
    .wperm   (end_wperm)
  );

  logic any_ena;
  logic chk_en, tbl_en;
  logic regcross, se_unaligned, mpu_miss, wperm_viol;

  always_comb begin
    any_ena = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) any_ena |= regions[i].ena;
  end

  // Combinational fault decode; table reads see the pre-write contents
  always_comb begin
    chk_en       = req_valid_d & ~req_dma_d;
    // An empty table means everything is permitted
    tbl_en       = chk_en & ~req_internal_d & any_ena;
    regcross     = chk_en & (req_start_addr_d[31:28] != req_end_addr_d[31:28]);
    se_unaligned = chk_en & req_sideeffect_d & ~req_internal_d &
                   is_unaligned(req_size_d, req_start_addr_d[1:0]);
    mpu_miss     = tbl_en & ~(start_hit & end_hit);
    wperm_viol   = tbl_en & start_hit & end_hit & req_store_d & ~(start_wperm & end_wperm);

    vd                  = '0;
    vd.valid            = req_valid_d;
    vd.addr             = req_start_addr_d;
    vd.misaligned_fault = regcross | se_unaligned;
    vd.access_fault     = mpu_miss | wperm_viol;
    if      (regcross)     vd.mscause = MSC_REGCROSS;
    else if (se_unaligned) vd.mscause = MSC_MISALIGN_SE;
    else if (mpu_miss)     vd.mscause = MSC_MPU;
    else if (wperm_viol)   vd.mscause = MSC_WPERM;
    else                   vd.mscause = MSC_NONE;
  end

  // ---------------- m stage ----------------
  // Verdict register, frozen while m is stalled
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)        vm <= '0;
    else if (!stall_m) vm <= vd;
  end

  assign chk_valid_m        = vm.valid;
  assign access_fault_m     = vm.access_fault;
  assign misaligned_fault_m = vm.misaligned_fault;
  assign exc_mscause_m      = vm.mscause;

  // ---------------- fault capture ----------------
  logic cap_ev;
  assign cap_ev = vm.valid & ~stall_m & (vm.access_fault | vm.misaligned_fault);

  // First fault sticks; a clear coinciding with a new fault reloads it
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fault_cap_valid <= 1'b0;
      fault_cap_addr  <= '0;
      fault_cap_cause <= '0;
    end else if (cap_ev && (!fault_cap_valid || fault_cap_clr)) begin
      fault_cap_valid <= 1'b1;
      fault_cap_addr  <= vm.addr;
      fault_cap_cause <= vm.mscause;
    end else if (fault_cap_clr) begin
      fault_cap_valid <= 1'b0;
    end
  end

`ifdef RV_MPU_FAULT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of every capture-qualified fault
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                       cnt_q <= '0;
    else if (cap_ev && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign fault_cnt = cnt_q;
`else
  assign fault_cnt = '0;
`endif

endmodule

// File: tb/tb_el2_lsu_mpu_check.sv
// Directed, table-driven bench for el2_lsu_mpu_check.
module tb_el2_lsu_mpu_check;
  logic        clk = 1'b0;
  logic        rst_l;
  logic        csr_wr_en;
  logic [2:0]  csr_wr_idx;
  logic [31:0] csr_wr_base, csr_wr_mask;
  logic        csr_wr_ena, csr_wr_wperm, csr_wr_lock;
  logic        req_valid_d;
  logic [31:0] req_start_addr_d, req_end_addr_d;
  logic [1:0]  req_size_d;
  logic        req_store_d, req_dma_d, req_internal_d, req_sideeffect_d;
  logic        stall_m;
  logic        chk_valid_m, access_fault_m, misaligned_fault_m;
  logic [3:0]  exc_mscause_m;
  logic        fault_cap_clr, fault_cap_valid;
  logic [31:0] fault_cap_addr;
  logic [3:0]  fault_cap_cause;
  logic [7:0]  fault_cnt;

  int checks = 0;
  int failures = 0;

  el2_lsu_mpu_check dut (
    .clk(clk), .rst_l(rst_l),
    .csr_wr_en(csr_wr_en), .csr_wr_idx(csr_wr_idx), .csr_wr_base(csr_wr_base),
    .csr_wr_mask(csr_wr_mask), .csr_wr_ena(csr_wr_ena), .csr_wr_wperm(csr_wr_wperm),
    .csr_wr_lock(csr_wr_lock),
    .req_valid_d(req_valid_d), .req_start_addr_d(req_start_addr_d),
    .req_end_addr_d(req_end_addr_d), .req_size_d(req_size_d), .req_store_d(req_store_d),
    .req_dma_d(req_dma_d), .req_internal_d(req_internal_d),
    .req_sideeffect_d(req_sideeffect_d), .stall_m(stall_m),
    .chk_valid_m(chk_valid_m), .access_fault_m(access_fault_m),
    .misaligned_fault_m(misaligned_fault_m), .exc_mscause_m(exc_mscause_m),
    .fault_cap_clr(fault_cap_clr), .fault_cap_valid(fault_cap_valid),
    .fault_cap_addr(fault_cap_addr), .fault_cap_cause(fault_cap_cause),
    .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] sa, ea;
    logic [1:0]  sz;
    logic        st, dma, intl, se;
    logic        e_acc, e_mis;
    logic [3:0]  e_cause;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic vld, logic [31:0] sa, logic [31:0] ea, logic [1:0] sz,
                              logic st, logic dma, logic intl, logic se,
                              logic e_acc, logic e_mis, logic [3:0] e_cause);
    vec_t v;
    v.vld = vld; v.sa = sa; v.ea = ea; v.sz = sz; v.st = st; v.dma = dma;
    v.intl = intl; v.se = se; v.e_acc = e_acc; v.e_mis = e_mis; v.e_cause = e_cause;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_m(input string nm, input logic v, input logic acc, input logic mis,
                       input logic [3:0] c);
    chk(nm, {25'd0, chk_valid_m, access_fault_m, misaligned_fault_m, exc_mscause_m},
        {25'd0, v, acc, mis, c});
  endtask

  task automatic chk_cap(input string nm, input logic v, input logic [31:0] a,
                         input logic [3:0] c);
    chk({nm, "_valid"}, {31'd0, fault_cap_valid}, {31'd0, v});
    chk({nm, "_addr"},  fault_cap_addr, a);
    chk({nm, "_cause"}, {28'd0, fault_cap_cause}, {28'd0, c});
  endtask

  task automatic chk_cnt(input string nm, input int exp_on);
`ifdef RV_MPU_FAULT_CNT_EN
    chk(nm, {24'd0, fault_cnt}, 32'(exp_on));
`else
    chk(nm, {24'd0, fault_cnt}, 32'(exp_on * 0));
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [31:0] sa, input logic [31:0] ea,
                     input logic [1:0] sz, input logic st, input logic dma,
                     input logic intl, input logic se);
    req_valid_d = v; req_start_addr_d = sa; req_end_addr_d = ea; req_size_d = sz;
    req_store_d = st; req_dma_d = dma; req_internal_d = intl; req_sideeffect_d = se;
  endtask

  task automatic idle();
    req(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_wr(input logic [2:0] idx, input logic [31:0] b, input logic [31:0] m,
                        input logic e, input logic w, input logic l);
    csr_wr_en = 1'b1; csr_wr_idx = idx; csr_wr_base = b; csr_wr_mask = m;
    csr_wr_ena = e; csr_wr_wperm = w; csr_wr_lock = l;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] b, input logic [31:0] m,
                    input logic e, input logic w, input logic l);
    set_wr(idx, b, m, e, w, l);
    cyc();
    csr_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_l = 1'b0;
    #10 rst_l = 1'b1;
    cyc();
  endtask

  task automatic ld(input logic [31:0] a);
    req(1'b1, a, a + 32'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stw(input logic [31:0] a);
    req(1'b1, a, a + 32'd3, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  int exp_cnt;

  initial begin
    rst_l = 1'b0; csr_wr_en = 1'b0; csr_wr_idx = '0; csr_wr_base = '0; csr_wr_mask = '0;
    csr_wr_ena = 1'b0; csr_wr_wperm = 1'b0; csr_wr_lock = 1'b0;
    stall_m = 1'b0; fault_cap_clr = 1'b0;
    idle();

    // Reset values
    #12;
    chk_m("reset_m", 1'b0, 1'b0, 1'b0, 4'd0);
    chk_cap("reset_cap", 1'b0, 32'h0, 4'd0);
    chk_cnt("reset_cnt", 0);
    @(negedge clk) rst_l = 1'b1;
    cyc();

    // Empty table: everything permitted
    ld(32'h2000_0000);
    cyc();
    chk_m("empty_tbl_load", 1'b1, 1'b0, 1'b0, 4'd0);
    idle();
    cyc();
    chk_cnt("empty_tbl_cnt", 0);

    // Region 0: read-only 64 KiB window at 0x2000_0000
    wr(3'd0, 32'h2000_0000, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);

    //          vld   start          end            sz    st    dma   int   se    acc   mis   cause
    vt.push_back(mk(1, 32'h2000_0010, 32'h2000_0013, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7));
    vt.push_back(mk(1, 32'h2000_0010, 32'h2000_0013, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    vt.push_back(mk(1, 32'h3000_0000, 32'h3000_0003, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3));
    vt.push_back(mk(1, 32'h2FFF_FFFF, 32'h3000_0000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2));
    vt.push_back(mk(1, 32'h3000_0000, 32'h3000_0003, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    vt.push_back(mk(1, 32'h3000_0000, 32'h3000_0003, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
    vt.push_back(mk(0, 32'h3000_0000, 32'h3000_0003, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    vt.push_back(mk(1, 32'h2000_0011, 32'h2000_0012, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1));
    vt.push_back(mk(1, 32'h2000_0012, 32'h2000_0015, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1));
    vt.push_back(mk(1, 32'h2000_0011, 32'h2000_0012, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
    vt.push_back(mk(1, 32'h2000_0010, 32'h2000_0013, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
    vt.push_back(mk(1, 32'h2000_FFFE, 32'h2001_0001, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3));
    vt.push_back(mk(1, 32'h3000_0000, 32'h3000_0003, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
    vt.push_back(mk(1, 32'h2000_0011, 32'h2000_0012, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1));

    exp_cnt = 0;
    foreach (vt[i]) begin
      req(vt[i].vld, vt[i].sa, vt[i].ea, vt[i].sz, vt[i].st, vt[i].dma, vt[i].intl, vt[i].se);
      cyc();
      chk_m($sformatf("vec%0d", i), vt[i].vld, vt[i].e_acc, vt[i].e_mis, vt[i].e_cause);
      if (vt[i].vld && (vt[i].e_acc || vt[i].e_mis)) exp_cnt++;
    end
    idle();
    cyc();
    chk_cap("tbl_first_fault", 1'b1, 32'h2000_0010, 4'd7);
    chk_cnt("tbl_cnt", exp_cnt);

    // Clear, then a region-crossing half store becomes the captured fault
    fault_cap_clr = 1'b1;
    cyc();
    fault_cap_clr = 1'b0;
    chk("clr_valid", {31'd0, fault_cap_valid}, 32'd0);
    req(1'b1, 32'h2FFF_FFFF, 32'h3000_0000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_m("regcross_m", 1'b1, 1'b1, 1'b1, 4'd2);
    idle();
    cyc();
    chk_cap("regcross_cap", 1'b1, 32'h2FFF_FFFF, 4'd2);

    // Lock region 0, then try to move it
    wr(3'd0, 32'h2000_0000, 32'h0000_FFFF, 1'b1, 1'b0, 1'b1);
    wr(3'd0, 32'h4000_0000, 32'h0000_FFFF, 1'b1, 1'b1, 1'b0);
    ld(32'h2000_0010);
    cyc();
    chk_m("locked_old_hit", 1'b1, 1'b0, 1'b0, 4'd0);
    ld(32'h4000_0010);
    cyc();
    chk_m("locked_new_miss", 1'b1, 1'b1, 1'b0, 4'd3);
    idle();

    // After reset the same write lands
    do_reset();
    wr(3'd0, 32'h4000_0000, 32'h0000_FFFF, 1'b1, 1'b1, 1'b0);
    ld(32'h4000_0010);
    cyc();
    chk_m("unlocked_new_hit", 1'b1, 1'b0, 1'b0, 4'd0);
    ld(32'h2000_0010);
    cyc();
    chk_m("unlocked_old_miss", 1'b1, 1'b1, 1'b0, 4'd3);

    // Write and check in one cycle: check sees the old (writable) entry
    set_wr(3'd0, 32'h4000_0000, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);
    stw(32'h4000_0010);
    cyc();
    csr_wr_en = 1'b0;
    chk_m("same_cycle_prewrite", 1'b1, 1'b0, 1'b0, 4'd0);
    cyc();
    chk_m("post_write_wperm", 1'b1, 1'b1, 1'b0, 4'd7);

    // Region 1 overlaps with wperm=1, but region 0 (lower) decides
    idle();
    wr(3'd1, 32'h4000_0000, 32'h0000_FFFF, 1'b1, 1'b1, 1'b0);
    stw(32'h4000_0010);
    cyc();
    chk_m("lowest_idx_wperm", 1'b1, 1'b1, 1'b0, 4'd7);
    idle();
    wr(3'd0, 32'h4000_0000, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    stw(32'h4000_0010);
    cyc();
    chk_m("region1_only", 1'b1, 1'b0, 1'b0, 4'd0);
    idle();

    // Back-to-back faults, a stall, then clear with a new fault
    do_reset();
    wr(3'd0, 32'h2000_0000, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);
    stw(32'h2000_0100);
    cyc();
    chk_m("b2b_f1", 1'b1, 1'b1, 1'b0, 4'd7);
    stw(32'h2000_0200);
    cyc();
    chk_m("b2b_f2", 1'b1, 1'b1, 1'b0, 4'd7);
    chk_cap("b2b_cap_f1", 1'b1, 32'h2000_0100, 4'd7);
    ld(32'h3000_0000);
    stall_m = 1'b1;
    cyc();
    chk_m("stall_hold", 1'b1, 1'b1, 1'b0, 4'd7);
    chk_cnt("stall_cnt", 1);
    stall_m = 1'b0;
    cyc();
    chk_m("b2b_f3", 1'b1, 1'b1, 1'b0, 4'd3);
    chk_cap("b2b_cap_keep", 1'b1, 32'h2000_0100, 4'd7);
    idle();
    fault_cap_clr = 1'b1;
    cyc();
    chk_cap("clr_with_fault", 1'b1, 32'h3000_0000, 4'd3);
    chk_cnt("b2b_cnt", 3);
    cyc();
    fault_cap_clr = 1'b0;
    chk("clr_alone", {31'd0, fault_cap_valid}, 32'd0);

    // Counter saturation
    ld(32'h3000_0000);
    for (int i = 0; i < 260; i++) cyc();
    idle();
    cyc();
    chk_cnt("cnt_saturate", 255);

    // Asynchronous reset mid-stream
    ld(32'h3000_0000);
    cyc();
    #2 rst_l = 1'b0;
    #1;
    chk_m("async_rst_m", 1'b0, 1'b0, 1'b0, 4'd0);
    chk_cap("async_rst_cap", 1'b0, 32'h0, 4'd0);
    chk_cnt("async_rst_cnt", 0);
    @(negedge clk) rst_l = 1'b1;
    cyc();
    cyc();
    chk_m("table_cleared", 1'b1, 1'b0, 1'b0, 4'd0);
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/el2_lsu_mpu_check.md
Name: el2_lsu_mpu_check

Overview:
- Next-generation LSU data-access checker: replaces static, parameter-only data-access windows with NUM_REGIONS run-time programmable regions (base/mask/enable/write-permit/lock).
- Checks the d-stage request against the table and registers the verdict into m-stage with stall support.
- Captures the first faulting address/cause for debug and keeps a saturating fault count.
- Sits beside the LSU address decode; DCCM/PIC range decode stays upstream and arrives as a qualifier.

Parameters:
- NUM_REGIONS, 8, number of programmable regions (1..16).
- IDX_W, $clog2(NUM_REGIONS) (min 1), region index width.
- CNT_W, 8, fault counter width.

Ports:
- clk  in  1  clock
- rst_l  in  1  reset; asynchronous, active-low
- csr_wr_en  in  1  region table write strobe
- csr_wr_idx  in  IDX_W  region written
- csr_wr_base  in  32  region base address
- csr_wr_mask  in  32  region mask (1 = don't-care bit)
- csr_wr_ena  in  1  region enable
- csr_wr_wperm  in  1  region write permitted
- csr_wr_lock  in  1  lock region until reset
- req_valid_d  in  1  request valid in d
- req_start_addr_d  in  32  start address
- req_end_addr_d  in  32  end address
- req_size_d  in  2  0 = byte, 1 = half, 2 = word
- req_store_d  in  1  store (else load)
- req_dma_d  in  1  DMA access (never faults)
- req_internal_d  in  1  address in DCCM/PIC region (table bypassed)
- req_sideeffect_d  in  1  side-effect region
- stall_m  in  1  hold m-stage register
- chk_valid_m  out  1  m-stage verdict valid
- access_fault_m  out  1  access fault
- misaligned_fault_m  out  1  misaligned fault
- exc_mscause_m  out  4  mscause
- fault_cap_clr  in  1  clear capture register
- fault_cap_valid  out  1  capture holds a fault
- fault_cap_addr  out  32  captured start address
- fault_cap_cause  out  4  captured mscause
- fault_cnt  out  CNT_W  saturating fault count

Behaviour:
- Reset: all outputs 0; table entries base = 0, mask = 0, ena = 0, wperm = 0, lock = 0.
- Table write: when csr_wr_en is high and entry[idx] lock = 0, the entry updates at the clock edge. A locked entry ignores writes until reset. An idx >= NUM_REGIONS is ignored. A check in the same cycle uses the pre-write table.
- Region match: ena & ((addr | mask) == (base | mask)). An address hits if any enabled region matches. Lowest matching index supplies wperm.
- If no region is enabled, every non-internal access is permitted.
- Faults are evaluated in d. They are suppressed when req_valid_d = 0 or req_dma_d = 1. Table check is skipped when req_internal_d = 1.
- Misaligned, priority order:
  - mscause 2 when start[31:28] != end[31:28];
  - else mscause 1 when sideeffect, non-internal, and unaligned (half with addr[0] set, word with addr[1:0] != 0).
- Access, priority order:
  - mscause 3 when start or end misses the table;
  - mscause 7 when store hits and the start or end hit region has wperm = 0.
- Misaligned takes precedence over access for exc_mscause.
- Pipeline: 1-cycle latency d -> m. With stall_m = 1 all m outputs hold. chk_valid_m = registered req_valid_d.
- Capture: on chk_valid_m & ~stall_m & (access_fault_m | misaligned_fault_m) with fault_cap_valid = 0, load addr/cause and set valid. Later faults do not overwrite.
  - fault_cap_clr clears valid.
  - Clear and a new fault in the same cycle: the new fault is loaded and valid stays 1.
- Counter: increments by 1 per captured-condition fault, whether or not capture is already valid. Saturates at all-ones.
- Reset asserted mid-operation: all state returns to reset values immediately (async).

Optional Feature:
- Macro RV_MPU_FAULT_CNT_EN.
- Defined: fault_cnt counter implemented as above.
- Undefined: no counter flops; fault_cnt tied to 0; port is kept.

Decomposition:
- el2_pkg gains el2_mpu_region_t (base[31:0], mask[31:0], ena, wperm, lock) and mscause localparams (MSC_MISALIGN_SE = 1, MSC_REGCROSS = 2, MSC_MPU = 3, MSC_WPERM = 7).
- Sub-module el2_mpu_region_match: combinational, one address vs the table array, outputs hit and wperm. Instantiated twice (start and end).

Test Plan:
- Reset, no regions enabled, load word at 0x2000_0000 -> next cycle chk_valid_m = 1, no fault, fault_cnt = 0.
- Region 0: base 0x2000_0000, mask 0x0000_FFFF, ena, wperm = 0.
  - Store to 0x2000_0010 -> access_fault_m = 1, mscause 7.
  - Load to the same address -> no fault.
  - Load to 0x3000_0000 -> mscause 3.
- Half store start 0x2FFF_FFFF, end 0x3000_0000 -> misaligned_fault_m = 1, mscause 2. Capture register holds addr 0x2FFF_FFFF, cause 2.
- Lock region 0, then write base 0x4000_0000 -> entry unchanged. Load to 0x2000_0010 still hits. After reset the write succeeds.
- Two faults back-to-back, then clear asserted with a third fault in the same cycle:
  - capture shows the first fault until the clear cycle, then the third;
  - fault_cnt = 3 (macro on) / 0 (macro off);
  - a stall during the fault holds m outputs unchanged.
